// File: rtl/vfd_scan_sequencer.sv
// ---------------------------------------------------------------------------
// vfd_scan_sequencer
//   Slot-based grid scan controller for a vacuum-fluorescent display.
//   Each slot is REFRESH_DIV clocks long. The slot opens with a shift of the
//   next grid's pattern. It closes with a blank window of BLK_CYCLES clocks.
//   A LAT_CYCLES latch pulse is issued at the start of the blank window, but
//   only when the shift finished in time. A shift still running when the
//   blank window opens is aborted and recorded in the sticky OVERRUN flag.
//
// Ports
//   CLK         system clock, all logic on the rising edge
//   RST_N       asynchronous active-low reset
//   EN          scan enable, sampled only at slot boundaries / in idle
//   SHIFT_DONE  one-cycle completion pulse from the shift engine
//   CLR_ERR     clears OVERRUN (a same-cycle new overrun wins)
//   SHIFT_START one-cycle pulse in the first cycle of every slot
//   SHIFT_ABORT one-cycle pulse when an unfinished shift is cancelled
//   GCP_EN      high while a shift is running
//   GRID_NUM    grid of the current slot, 1..GRID_COUNT
//   BLK         display blanking
//   LAT         serial latch
//   FRAME_TICK  one-cycle pulse at the start of the slot after a grid wrap
//   OVERRUN     sticky shift-overrun flag
// ---------------------------------------------------------------------------
module vfd_scan_sequencer #(
  parameter int REFRESH_DIV = 3846,
  parameter int GRID_COUNT  = 52,
  parameter int BLK_CYCLES  = 120,
  parameter int LAT_CYCLES  = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       SHIFT_DONE,
  input  logic       CLR_ERR,
  output logic       SHIFT_START,
  output logic       SHIFT_ABORT,
  output logic       GCP_EN,
  output logic [5:0] GRID_NUM,
  output logic       BLK,
  output logic       LAT,
  output logic       FRAME_TICK,
  output logic       OVERRUN
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam logic [TW-1:0] SLOT_END  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] BLK_START = TW'(REFRESH_DIV - BLK_CYCLES);
  localparam logic [TW-1:0] LAT_END   = TW'(REFRESH_DIV - BLK_CYCLES + LAT_CYCLES - 1);
  localparam logic [5:0]    GRID_LAST = 6'(GRID_COUNT);

  if ((REFRESH_DIV <= BLK_CYCLES + 1) || (LAT_CYCLES < 1) || (LAT_CYCLES > BLK_CYCLES) ||
      (GRID_COUNT < 1) || (GRID_COUNT > 63)) begin : g_param_check
    $error("vfd_scan_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t        state_r, nxt_state_s;
  logic [TW-1:0] timer_r, nxt_timer_s;
  logic [5:0]    grid_r, nxt_grid_s;
  logic          latch_ok_r, nxt_latch_ok_s;
  logic          overrun_r, nxt_overrun_s;
  logic          ovr_set_s;
  logic          nxt_frame_tick_s;
  logic          nxt_in_slot_s;

  // Registered copies of the slot-derived outputs, decoded from next state.
  logic          shift_start_r;
  logic          gcp_en_r;
  logic          blk_r;
  logic          frame_tick_r;
  // lat_win_r: latch window cycle with a completed shift already recorded.
  logic          lat_win_r;
  // blank_shift_r: first blank-window cycle reached while still shifting.
  logic          blank_shift_r;

  // Next-state, timer, grid, latch_ok and overrun decisions.
  always_comb begin
    nxt_state_s      = state_r;
    nxt_timer_s      = timer_r;
    nxt_grid_s       = grid_r;
    nxt_latch_ok_s   = latch_ok_r;
    ovr_set_s        = 1'b0;
    nxt_frame_tick_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        nxt_timer_s    = '0;
        nxt_latch_ok_s = 1'b0;
        if (EN) begin
          nxt_state_s = ST_SHIFT;
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_SHIFT, ST_HOLD: begin
        if (timer_r == SLOT_END) begin
          nxt_timer_s    = '0;
          nxt_latch_ok_s = 1'b0;
          if (grid_r >= GRID_LAST) begin
            nxt_grid_s       = 6'd1;
            nxt_frame_tick_s = EN;
          end else begin
            nxt_grid_s = grid_r + 6'd1;
          end
          if (EN) begin
            nxt_state_s = ST_SHIFT;
          end else begin
            nxt_state_s = ST_IDLE;
          end
        end else begin
          nxt_timer_s = timer_r + TW'(1);
          if (state_r == ST_SHIFT) begin
            // A completion in the blank-start cycle still counts as done.
            if (SHIFT_DONE) begin
              nxt_state_s    = ST_HOLD;
              nxt_latch_ok_s = 1'b1;
            end else if (timer_r == BLK_START) begin
              nxt_state_s = ST_HOLD;
              ovr_set_s   = 1'b1;
            end else begin
              nxt_state_s = ST_SHIFT;
            end
          end else begin
            nxt_state_s = ST_HOLD;
          end
        end
      end
      default: begin
        nxt_state_s    = ST_IDLE;
        nxt_timer_s    = '0;
        nxt_latch_ok_s = 1'b0;
      end
    endcase
    // A new overrun takes priority over a same-cycle clear.
    nxt_overrun_s = ovr_set_s | (overrun_r & ~CLR_ERR);
    nxt_in_slot_s = (nxt_state_s != ST_IDLE);
  end

  // State, counters, flags and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r       <= ST_IDLE;
      timer_r       <= '0;
      grid_r        <= 6'd1;
      latch_ok_r    <= 1'b0;
      overrun_r     <= 1'b0;
      shift_start_r <= 1'b0;
      gcp_en_r      <= 1'b0;
      blk_r         <= 1'b1;
      frame_tick_r  <= 1'b0;
      lat_win_r     <= 1'b0;
      blank_shift_r <= 1'b0;
    end else begin
      state_r       <= nxt_state_s;
      timer_r       <= nxt_timer_s;
      grid_r        <= nxt_grid_s;
      latch_ok_r    <= nxt_latch_ok_s;
      overrun_r     <= nxt_overrun_s;
      shift_start_r <= (nxt_state_s == ST_SHIFT) && (nxt_timer_s == '0);
      gcp_en_r      <= (nxt_state_s == ST_SHIFT);
      blk_r         <= ~nxt_in_slot_s || (nxt_timer_s >= BLK_START);
      frame_tick_r  <= nxt_frame_tick_s;
      lat_win_r     <= nxt_in_slot_s && nxt_latch_ok_s &&
                       (nxt_timer_s >= BLK_START) && (nxt_timer_s <= LAT_END);
      blank_shift_r <= (nxt_state_s == ST_SHIFT) && (nxt_timer_s == BLK_START);
    end
  end

  // In the blank-start cycle a still-running shift is either completed by a
  // same-cycle SHIFT_DONE (latch it) or cancelled (abort); this is the only
  // output path that depends on an input combinationally.
  assign LAT         = lat_win_r | (blank_shift_r & SHIFT_DONE);
  assign SHIFT_ABORT = blank_shift_r & ~SHIFT_DONE;
  assign SHIFT_START = shift_start_r;
  assign GCP_EN      = gcp_en_r;
  assign GRID_NUM    = grid_r;
  assign BLK         = blk_r;
  assign FRAME_TICK  = frame_tick_r;
  assign OVERRUN     = overrun_r;

endmodule
